// File: rtl/instr_encoder.sv
// Field-to-word instruction encoder that packs 32-bit and compressed 16-bit
// instructions into a little-endian stream of 32-bit memory words.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [19:0] imm,
  input  logic [15:0] c_half,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        err,
  output logic [15:0] word_cnt
);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                         FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5,
                         FMT_C = 3'd6, FMT_X = 3'd7;

  typedef enum logic {EMPTY, HALF} state_t;

  state_t      state, nxt_state;
  logic [15:0] pend, nxt_pend;
  logic [31:0] instr, load_data;
  logic        load, accept, is_c16, is_32, bad, do_flush;

  always_comb begin
    instr = 32'h0;
    case (fmt)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: instr = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
      FMT_U: instr = {imm[19:0], rd, opcode};
      FMT_J: instr = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
      default: instr = 32'h0;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_c16   = (fmt == FMT_C);
  assign is_32    = (fmt != FMT_C) && (fmt != FMT_X);
  assign do_flush = flush && !in_valid && in_ready;
  // Reserved formats are swallowed here: they only raise err below.
  assign bad      = accept && ((fmt == FMT_X) ||
                               (is_32 && opcode[1:0] != 2'b11) ||
                               (is_c16 && c_half[1:0] == 2'b11));

  always_comb begin
    nxt_state = state;
    nxt_pend  = pend;
    load      = 1'b0;
    load_data = instr;
    case (state)
      EMPTY: begin
        if (accept && is_32) begin
          load = 1'b1;
        end else if (accept && is_c16) begin
          nxt_pend  = c_half;
          nxt_state = HALF;
        end
      end
      HALF: begin
        if (accept && is_c16) begin
          load      = 1'b1;
          load_data = {c_half, pend};
          nxt_state = EMPTY;
        end else if (accept && is_32) begin
          // Word straddles the boundary: low half goes out, high half waits.
          load      = 1'b1;
          load_data = {instr[15:0], pend};
          nxt_pend  = instr[31:16];
        end else if (do_flush) begin
          load      = 1'b1;
          load_data = {16'h0001, pend};
          nxt_state = EMPTY;
        end
      end
      default: nxt_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      pend  <= 16'h0;
    end else begin
      state <= nxt_state;
      pend  <= nxt_pend;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      err       <= 1'b0;
      word_cnt  <= 16'h0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) word_cnt <= word_cnt + 16'd1;
      if (bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against a half-word stream
// model: every instruction becomes 16-bit chunks, and any two chunks form a word.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  fmt = 3'd0;
  logic [6:0]  opcode = 7'h0;
  logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'h0;
  logic [19:0] imm = 20'h0;
  logic [15:0] c_half = 16'h0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_data;
  logic        err;
  logic [15:0] word_cnt;

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .c_half(c_half),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  logic [15:0] hq[$];
  logic        m_valid = 1'b0, m_err = 1'b0;
  logic [31:0] m_data = 32'h0;
  logic [15:0] m_cnt = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Encoding from the branch/jump byte offsets rather than the packed fields.
  function automatic logic [31:0] enc(input logic [2:0] f);
    logic [31:0] o, i12, r, s1, s2, d, f3, op;
    r  = 32'(rs2) << 20;
    s1 = 32'(rs1) << 15;
    s2 = r;
    d  = 32'(rd) << 7;
    f3 = 32'(funct3) << 12;
    op = 32'(opcode);
    i12 = 32'(imm[11:0]);
    case (f)
      3'd0: enc = (32'(funct7) << 25) | s2 | s1 | f3 | d | op;
      3'd1: enc = (i12 << 20) | s1 | f3 | d | op;
      3'd2: enc = ((i12 >> 5) << 25) | s2 | s1 | f3 | ((i12 & 32'h1F) << 7) | op;
      3'd3: begin
        o = (32'(imm[11]) << 12) | (32'(imm[10]) << 11) |
            (32'(imm[9:4]) << 5) | (32'(imm[3:0]) << 1);
        enc = (((o >> 12) & 1) << 31) | (((o >> 5) & 32'h3F) << 25) | s2 | s1 | f3 |
              (((o >> 1) & 32'hF) << 8) | (((o >> 11) & 1) << 7) | op;
      end
      3'd4: enc = (32'(imm) << 12) | d | op;
      3'd5: begin
        o = (32'(imm[19]) << 20) | (32'(imm[18:11]) << 12) |
            (32'(imm[10]) << 11) | (32'(imm[9:0]) << 1);
        enc = (((o >> 20) & 1) << 31) | (((o >> 1) & 32'h3FF) << 21) |
              (((o >> 11) & 1) << 20) | (((o >> 12) & 32'hFF) << 12) | d | op;
      end
      default: enc = 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] w;
    logic rdy;
    rdy = !m_valid || out_ready;
    if (m_valid && out_ready) m_cnt = m_cnt + 16'd1;
    if (in_valid && rdy) begin
      if (fmt == 3'd7) m_err = 1'b1;
      else if (fmt == 3'd6) begin
        if (c_half[1:0] == 2'b11) m_err = 1'b1;
        hq.push_back(c_half);
      end else begin
        w = enc(fmt);
        if (opcode[1:0] != 2'b11) m_err = 1'b1;
        hq.push_back(w[15:0]);
        hq.push_back(w[31:16]);
      end
    end else if (flush && !in_valid && rdy && hq.size() == 1) begin
      hq.push_back(16'h0001);
    end
    if (hq.size() >= 2) begin
      m_data = {hq[1], hq[0]};
      void'(hq.pop_front());
      void'(hq.pop_front());
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1 with outputs checked.
  task automatic step();
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    model_edge();
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", out_data, m_data);
    chk("err", 32'(err), 32'(m_err));
    chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    hq.delete();
    m_valid = 1'b0; m_data = 32'h0; m_cnt = 16'h0; m_err = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_word_cnt", 32'(word_cnt), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_r(input logic [6:0] f7, input logic [4:0] a2, input logic [4:0] a1,
                        input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    fmt = 3'd0; funct7 = f7; rs2 = a2; rs1 = a1; funct3 = f3; rd = d; opcode = op;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_j(input logic [4:0] d, input logic [6:0] op, input logic [19:0] im);
    fmt = 3'd5; rd = d; opcode = op; imm = im;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_c(input logic [15:0] c);
    fmt = 3'd6; c_half = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] cnt0;
    do_reset();

    send_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_data", out_data, 32'h002081B3);
    step();
    chk("add_cnt", 32'(word_cnt), 32'h1);

    send_j(5'd1, 7'h6F, 20'h80000);
    chk("jal_data", out_data, 32'h800000EF);
    step();

    send_c(16'h4501);
    chk("c16_first_noout", 32'(out_valid), 32'h0);
    send_c(16'h4585);
    chk("c16_pair", out_data, 32'h45854501);
    step();

    send_c(16'h4501);
    send_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
    chk("straddle", out_data, 32'h81B34501);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_word", out_data, 32'h00010020);
    step();
    send_c(16'h4585);
    chk("empty_after_flush", 32'(out_valid), 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_c16", out_data, 32'h00014585);
    step();

    out_ready = 1'b0;
    send_r(7'h20, 5'd5, 5'd6, 3'd0, 5'd7, 7'h33);
    cnt0 = word_cnt;
    repeat (3) begin
      step();
      chk("hold_data", out_data, 32'h405303B3);
      chk("hold_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    step();
    chk("release_valid", 32'(out_valid), 32'h0);
    chk("release_cnt", 32'(word_cnt), 32'(cnt0 + 16'd1));

    fmt = 3'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rsv_err", 32'(err), 32'h1);
    chk("rsv_noout", 32'(out_valid), 32'h0);

    send_c(16'h4501);
    do_reset();
    send_c(16'h4585);
    chk("post_rst_noout", 32'(out_valid), 32'h0);
    chk("post_rst_err", 32'(err), 32'h0);
    chk("post_rst_cnt", 32'(word_cnt), 32'h0);
    step();
    chk("post_rst_still", 32'(out_valid), 32'h0);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) == 0) do_reset();
      out_ready = ($urandom_range(9) < 7);
      in_valid  = $urandom_range(1);
      flush     = ($urandom_range(4) == 0);
      fmt       = 3'($urandom_range(7));
      opcode    = 7'($urandom);
      if ($urandom_range(9) != 0) opcode[1:0] = 2'b11;
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3 = 3'($urandom); funct7 = 7'($urandom);
      imm = 20'($urandom);
      c_half = 16'($urandom);
      if ($urandom_range(9) != 0 && c_half[1:0] == 2'b11) c_half[0] = 1'b0;
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: in_valid  input  1  instruction fields valid.
REQ-004 SHALL have ports: in_ready  output  1  fields accepted this cycle when in_valid & in_ready.
REQ-005 SHALL have ports: fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=C16, 7=reserved.
REQ-006 SHALL have ports: opcode  input  7; rd, rs1, rs2  input  5 each; funct3  input  3; funct7  input  7.
REQ-007 SHALL have ports: imm  input  20  I/S use imm[11:0]; B uses packed {i31,i7,i30:25,i11:8}; J uses packed {i31,i19:12,i20,i30:21}; U uses imm[19:0].
REQ-008 SHALL have ports: c_half  input  16  raw compressed instruction for fmt=C16.
REQ-009 SHALL have ports: flush  input  1  pad and emit a pending half-word.
REQ-010 SHALL have ports: out_valid  output  1; out_ready  input  1; out_data  output  32  packed little-endian instruction memory word.
REQ-011 SHALL have ports: err  output  1  sticky illegal-input flag.
REQ-012 SHALL have ports: word_cnt  output  16  count of words emitted.

Function
REQ-013 SHALL encode: R {funct7,rs2,rs1,funct3,rd,opcode}; I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-014 SHALL encode: B {imm[11],imm[9:4],rs2,rs1,funct3,imm[3:0],imm[10],opcode}; U {imm[19:0],rd,opcode}; J {imm[19],imm[9:0],imm[10],imm[18:11],rd,opcode}.
REQ-015 SHALL hold one output register; in_ready = !out_valid | out_ready, combinational.
REQ-016 SHALL implement states EMPTY (no pending half) and HALF (16-bit pend register valid).
REQ-017 SHALL, in EMPTY on an accepted 32-bit instruction: load out_data=instr next cycle; out_valid=1; stay EMPTY.
REQ-018 SHALL, in EMPTY on an accepted C16: pend=c_half; go HALF; no output.
REQ-019 SHALL, in HALF on an accepted C16: out_data={c_half,pend}; go EMPTY.
REQ-020 SHALL, in HALF on an accepted 32-bit instruction: out_data={instr[15:0],pend}; pend=instr[31:16]; stay HALF.
REQ-021 SHALL act on flush only when in_valid=0 and in_ready=1; in HALF it emits {16'h0001,pend} and goes EMPTY; in EMPTY it is a no-op.
REQ-022 SHALL clear out_valid on out_ready when no new word is loaded the same cycle; it SHALL not change out_data while out_valid & !out_ready.
REQ-023 SHALL increment word_cnt by 1 per out_valid & out_ready handshake; it wraps 16'hFFFF -> 0.
REQ-024 SHALL set err and keep it set until reset on any accepted instruction that meets one of these conditions: fmt=7, which is consumed and dropped with no state change; a 32-bit fmt with opcode[1:0] != 2'b11, which is still emitted; or C16 with c_half[1:0] == 2'b11, which is still packed.
REQ-025 SHALL give 1-cycle latency from accept to out_valid for every word-producing event.

Reset
REQ-026 SHALL, while rst=1, asynchronously force: state=EMPTY, pend=0, out_valid=0, out_data=0, err=0, word_cnt=0. in_ready is then 1.
REQ-027 SHALL discard a pending half, and any unaccepted output word, on reset mid-operation.
REQ-028 SHALL accept input on the first rising clk edge after rst deasserts.

Verification
REQ-029 SHALL be verified by bench scenarios covering the following.
- R add x3,x1,x2 (funct7=0, rs2=2, rs1=1, funct3=0, rd=3, opcode=0x33) -> out_data=0x002081B3 one cycle later; word_cnt=1 after handshake.
- J fmt, rd=1, opcode=0x6F, imm=20'h80000 -> out_data=0x800000EF.
- C16 0x4501 then C16 0x4585 -> single word 0x45854501; no output after the first.
- C16 0x4501, then the R word from the first scenario, then flush -> 0x81B34501, then 0x00010020; state EMPTY.
- out_ready=0 for 3 cycles with a word held -> out_data stable, in_ready=0; output released on the first cycle out_ready=1.
- rst pulse while in HALF (pend=0x4501) -> no word emitted; next C16 0x4585 alone yields no output; err=0, word_cnt=0.
